ctrl_mem: RTL and testbench

CTRL_MEM -- requirements
Module: ctrl_mem

---
 rtl/ctrl_mem_pkg.sv | 24 ++
 rtl/ctrl_mem.sv | 116 +++++++++++
 tb/tb_ctrl_mem.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/ctrl_mem_pkg.sv
// Shared CPU definitions for the MEM-stage controller: opcodes, NOP, FSM states
// and the instruction decode helpers.
package ctrl_mem_pkg;

  localparam logic [3:0]  OP_LD      = 4'b1000;
  localparam logic [3:0]  OP_ST      = 4'b1001;
  localparam logic [3:0]  OP_ALU_MAX = 4'b0111;
  localparam logic [15:0] NOP        = 16'h0000;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } ctrl_state_e;

  function automatic logic is_mem_op(input logic [15:0] ir);
    return (ir[15:12] == OP_LD) || (ir[15:12] == OP_ST);
  endfunction

  // ALU ops and loads write the register file; NOP never does.
  function automatic logic writes_reg(input logic [15:0] ir);
    return ((ir[15:12] <= OP_ALU_MAX) || (ir[15:12] == OP_LD)) && (ir != NOP);
  endfunction

endpackage

// File: rtl/ctrl_mem.sv
// MEM-stage controller: stalls the pipe around data-memory accesses and feeds WB.
// Define CTRL_MEM_TIMEOUT_EN to compile in the access timeout (o_mem_err).
import ctrl_mem_pkg::*;

module ctrl_mem #(
  parameter int unsigned TIMEOUT_CYCLES = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] i_ir_mem,
  input  logic        i_mem_ack,
  output logic        o_mem_req,
  output logic        o_mem_we,
  output logic        o_stall,
  output logic [15:0] o_ir_wb,
  output logic        o_wb_en,
  output logic        o_mem_err
);

  ctrl_state_e state_r;
  ctrl_state_e next_state_s;
  logic        stall_s;
  logic [15:0] ir_next_s;
  logic        timeout_s;
  logic        st_r;

`ifdef CTRL_MEM_TIMEOUT_EN
  localparam logic [3:0] LIMIT = 4'(TIMEOUT_CYCLES - 1);
  logic [3:0] cnt_r;

  assign timeout_s = (state_r == BUSY) && (cnt_r == LIMIT);

  // Access-age counter: held at zero while idle so it starts clean on BUSY entry.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_r <= 4'd0;
    end else if (state_r == IDLE) begin
      cnt_r <= 4'd0;
    end else if (!i_mem_ack) begin
      cnt_r <= cnt_r + 4'd1;
    end else begin
      cnt_r <= cnt_r;
    end
  end

  // Timeout pulse; a simultaneous ack takes priority.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      o_mem_err <= 1'b0;
    end else begin
      o_mem_err <= timeout_s && !i_mem_ack;
    end
  end
`else
  assign timeout_s = 1'b0;
  assign o_mem_err = 1'b0;
`endif

  // Next-state, stall and WB-stage instruction selection.
  always_comb begin
    next_state_s = state_r;
    stall_s      = 1'b0;
    ir_next_s    = i_ir_mem;
    case (state_r)
      IDLE: begin
        if (is_mem_op(i_ir_mem)) begin
          next_state_s = BUSY;
          stall_s      = 1'b1;
          ir_next_s    = NOP;
        end else begin
          next_state_s = IDLE;
        end
      end
      BUSY: begin
        if (i_mem_ack) begin
          next_state_s = IDLE;
        end else if (timeout_s) begin
          next_state_s = IDLE;
          ir_next_s    = NOP;
        end else begin
          stall_s   = 1'b1;
          ir_next_s = NOP;
        end
      end
      default: begin
        next_state_s = IDLE;
        ir_next_s    = NOP;
      end
    endcase
  end

  // State, store flag and WB-stage registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= IDLE;
      st_r    <= 1'b0;
      o_ir_wb <= NOP;
      o_wb_en <= 1'b0;
    end else begin
      state_r <= next_state_s;
      if (state_r == IDLE) begin
        st_r <= (i_ir_mem[15:12] == OP_ST);
      end else begin
        st_r <= st_r;
      end
      o_ir_wb <= ir_next_s;
      o_wb_en <= writes_reg(ir_next_s);
    end
  end

  assign o_mem_req = (state_r == BUSY);
  assign o_mem_we  = (state_r == BUSY) && st_r;
  // Gate the combinational stall so it stays low while reset is held.
  assign o_stall   = stall_s && rst;

endmodule

// File: tb/tb_ctrl_mem.sv
// Directed self-checking bench for ctrl_mem; covers the timeout path when
// CTRL_MEM_TIMEOUT_EN is defined.
module tb_ctrl_mem;
  import ctrl_mem_pkg::*;

`ifdef CTRL_MEM_TIMEOUT_EN
  localparam int unsigned TO = 4;
`else
  localparam int unsigned TO = 15;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] i_ir_mem;
  logic        i_mem_ack;
  logic        o_mem_req, o_mem_we, o_stall, o_wb_en, o_mem_err;
  logic [15:0] o_ir_wb;

  int vectors = 0;
  int errors  = 0;

  ctrl_mem #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst), .i_ir_mem(i_ir_mem), .i_mem_ack(i_mem_ack),
    .o_mem_req(o_mem_req), .o_mem_we(o_mem_we), .o_stall(o_stall),
    .o_ir_wb(o_ir_wb), .o_wb_en(o_wb_en), .o_mem_err(o_mem_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0; i_ir_mem = 16'h8123; i_mem_ack = 1'b0;
    #1;
    chk("rst_ir_wb", o_ir_wb, 16'h0000);
    chk("rst_wb_en", {15'd0, o_wb_en}, 16'd0);
    chk("rst_err",   {15'd0, o_mem_err}, 16'd0);
    chk("rst_req",   {15'd0, o_mem_req}, 16'd0);
    chk("rst_we",    {15'd0, o_mem_we}, 16'd0);
    chk("rst_stall", {15'd0, o_stall}, 16'd0);

    // ALU passthrough
    @(negedge clk); rst = 1'b1; i_ir_mem = 16'h1234;
    #1 chk("alu_stall", {15'd0, o_stall}, 16'd0);
    tick();
    chk("alu_ir_wb", o_ir_wb, 16'h1234);
    chk("alu_wb_en", {15'd0, o_wb_en}, 16'd1);
    chk("alu_req",   {15'd0, o_mem_req}, 16'd0);

    // LD with ack on the 3rd BUSY cycle
    i_ir_mem = 16'h8123;
    #1 chk("ld_idle_stall", {15'd0, o_stall}, 16'd1);
    chk("ld_idle_req", {15'd0, o_mem_req}, 16'd0);
    tick();
    chk("ld_b1_req",   {15'd0, o_mem_req}, 16'd1);
    chk("ld_b1_we",    {15'd0, o_mem_we}, 16'd0);
    chk("ld_b1_stall", {15'd0, o_stall}, 16'd1);
    chk("ld_b1_ir_wb", o_ir_wb, 16'h0000);
    tick();
    chk("ld_b2_stall", {15'd0, o_stall}, 16'd1);
    chk("ld_b2_req",   {15'd0, o_mem_req}, 16'd1);
    tick();
    i_mem_ack = 1'b1;
    #1 chk("ld_b3_stall", {15'd0, o_stall}, 16'd0);
    chk("ld_b3_req", {15'd0, o_mem_req}, 16'd1);
    tick();
    i_mem_ack = 1'b0; i_ir_mem = 16'h0000;
    #1 chk("ld_done_req", {15'd0, o_mem_req}, 16'd0);
    chk("ld_done_ir_wb", o_ir_wb, 16'h8123);
    chk("ld_done_wb_en", {15'd0, o_wb_en}, 16'd1);
    chk("ld_done_stall", {15'd0, o_stall}, 16'd0);

    // ST with immediate ack, then back-to-back LD
    i_ir_mem = 16'h9456;
    #1 chk("st_idle_stall", {15'd0, o_stall}, 16'd1);
    tick();
    chk("st_b1_we",  {15'd0, o_mem_we}, 16'd1);
    chk("st_b1_req", {15'd0, o_mem_req}, 16'd1);
    i_mem_ack = 1'b1;
    #1 chk("st_b1_stall", {15'd0, o_stall}, 16'd0);
    tick();
    i_mem_ack = 1'b0; i_ir_mem = 16'h8AAA;
    #1 chk("st_done_we",    {15'd0, o_mem_we}, 16'd0);
    chk("b2b_gap_req",      {15'd0, o_mem_req}, 16'd0);
    chk("st_done_ir_wb",    o_ir_wb, 16'h9456);
    chk("st_done_wb_en",    {15'd0, o_wb_en}, 16'd0);
    chk("b2b_gap_stall",    {15'd0, o_stall}, 16'd1);
    tick();
    chk("b2b_req", {15'd0, o_mem_req}, 16'd1);
    chk("b2b_we",  {15'd0, o_mem_we}, 16'd0);
    i_mem_ack = 1'b1;
    tick();
    i_mem_ack = 1'b0; i_ir_mem = 16'h0000;
    #1 chk("b2b_ir_wb", o_ir_wb, 16'h8AAA);

    // Stray ack in IDLE with an ALU op, then a non-writing op and NOP
    i_ir_mem = 16'h2345; i_mem_ack = 1'b1;
    #1 chk("stray_stall", {15'd0, o_stall}, 16'd0);
    tick();
    i_mem_ack = 1'b0; i_ir_mem = 16'hA111;
    chk("stray_ir_wb", o_ir_wb, 16'h2345);
    chk("stray_wb_en", {15'd0, o_wb_en}, 16'd1);
    chk("stray_req",   {15'd0, o_mem_req}, 16'd0);
    chk("stray_err",   {15'd0, o_mem_err}, 16'd0);
    tick();
    i_ir_mem = 16'h0000;
    chk("nonwr_ir_wb", o_ir_wb, 16'hA111);
    chk("nonwr_wb_en", {15'd0, o_wb_en}, 16'd0);
    tick();
    chk("nop_wb_en", {15'd0, o_wb_en}, 16'd0);

    // Reset during BUSY, stray ack after release
    i_ir_mem = 16'h8123;
    tick();
    chk("rb_req_before", {15'd0, o_mem_req}, 16'd1);
    #2 rst = 1'b0;
    #1 chk("rb_req_async", {15'd0, o_mem_req}, 16'd0);
    chk("rb_stall", {15'd0, o_stall}, 16'd0);
    chk("rb_ir_wb", o_ir_wb, 16'h0000);
    @(negedge clk); rst = 1'b1; i_ir_mem = 16'h0000; i_mem_ack = 1'b1;
    tick();
    i_mem_ack = 1'b0;
    chk("rb_post_req",   {15'd0, o_mem_req}, 16'd0);
    chk("rb_post_ir_wb", o_ir_wb, 16'h0000);
    chk("rb_post_err",   {15'd0, o_mem_err}, 16'd0);

`ifdef CTRL_MEM_TIMEOUT_EN
    // Timeout after 4 BUSY cycles without ack
    i_ir_mem = 16'h8123;
    tick(); tick(); tick();
    chk("to_b3_stall", {15'd0, o_stall}, 16'd1);
    tick();
    chk("to_b4_stall", {15'd0, o_stall}, 16'd0);
    chk("to_b4_err",   {15'd0, o_mem_err}, 16'd0);
    i_ir_mem = 16'h0000;
    tick();
    chk("to_err",   {15'd0, o_mem_err}, 16'd1);
    chk("to_ir_wb", o_ir_wb, 16'h0000);
    chk("to_wb_en", {15'd0, o_wb_en}, 16'd0);
    chk("to_req",   {15'd0, o_mem_req}, 16'd0);
    tick();
    chk("to_err_once", {15'd0, o_mem_err}, 16'd0);

    // Ack on the limit cycle wins
    i_ir_mem = 16'h8321;
    tick(); tick(); tick(); tick();
    i_mem_ack = 1'b1;
    tick();
    i_mem_ack = 1'b0; i_ir_mem = 16'h0000;
    chk("lim_err",   {15'd0, o_mem_err}, 16'd0);
    chk("lim_ir_wb", o_ir_wb, 16'h8321);
    chk("lim_wb_en", {15'd0, o_wb_en}, 16'd1);
`else
    // No timeout: BUSY holds well past TIMEOUT_CYCLES
    i_ir_mem = 16'h8123;
    for (int i = 0; i < 20; i++) tick();
    chk("wait_req",   {15'd0, o_mem_req}, 16'd1);
    chk("wait_stall", {15'd0, o_stall}, 16'd1);
    chk("wait_err",   {15'd0, o_mem_err}, 16'd0);
    i_mem_ack = 1'b1;
    tick();
    i_mem_ack = 1'b0; i_ir_mem = 16'h0000;
    chk("wait_ir_wb", o_ir_wb, 16'h8123);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
